// File: rtl/vc_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and
// default parameter values used by vc_rst_seq and its bench.
package vc_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REL    = 2'd2,
    ST_RUN    = 2'd3
  } vc_state_e;

  localparam int VC_NCH   = 3;
  localparam int VC_SYNC  = 2;
  localparam int VC_HOLD  = 16;
  localparam int VC_GAP   = 4;
  localparam int VC_MODEW = 2;
  localparam int VC_WDOG  = 4096;

endpackage

// File: rtl/vc_sync.sv
// Pad reset synchroniser: SYNC-flop chain that resets to all-ones so the
// synchronised reset reads asserted until real samples have propagated.
module vc_sync #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC-1:0] chain;

  // Shift the raw pad level through the chain; preset to asserted on reset.
  always_ff @(posedge clk) begin
    if (reset) chain <= '1;
    else       chain <= {chain[SYNC-2:0], d};
  end

  assign q = chain[SYNC-1];

endmodule

// File: rtl/vc_rst_seq.sv
// Sequenced reset controller: holds all channels in reset while any reset
// cause is present, then releases them one at a time in ascending order.
// Supports masked software resets from RUN. Optional watchdog is enabled by
// defining VC_RST_WDOG_EN; without it kick is ignored and wdog_fired is 0.
module vc_rst_seq
  import vc_pkg::*;
#(
  parameter int NCH   = VC_NCH,
  parameter int SYNC  = VC_SYNC,
  parameter int HOLD  = VC_HOLD,
  parameter int GAP   = VC_GAP,
  parameter int MODEW = VC_MODEW,
  parameter int WDOG  = VC_WDOG
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rst_n_pin,
  input  logic             ena,
  input  logic [MODEW-1:0] mode_pins,
  input  logic             soft_req,
  input  logic [NCH-1:0]   soft_mask,
  input  logic             kick,
  output logic [NCH-1:0]   ch_reset,
  output logic [MODEW-1:0] boot_mode,
  output logic             ready,
  output logic             wdog_fired
);

  localparam int CMAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = $clog2(CMAX + 1);

  logic           pad_rst;
  logic           rst_any;
  logic           hard_clr;
  vc_state_e      state;
  logic [CW-1:0]  cnt;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] first;
  logic           soft_seq;
  logic           soft_go;
  logic           wdog_hit;

  vc_sync #(.SYNC(SYNC)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (~rst_n_pin),
    .q     (pad_rst)
  );

  assign rst_any  = reset | ~ena | pad_rst;
  assign hard_clr = reset | ~ena;
  // pend holds the channels still waiting for release; take its lowest bit.
  assign first    = pend & (~pend + NCH'(1));
  assign soft_go  = (state == ST_RUN) && soft_req && (|soft_mask);

`ifdef VC_RST_WDOG_EN
  localparam int WW = $clog2(WDOG + 1);
  logic [WW-1:0] wcnt;

  assign wdog_hit = (state == ST_RUN) && !kick && (wcnt == WW'(WDOG - 1));

  // Watchdog counter: runs only in RUN, cleared by kick or leaving RUN.
  always_ff @(posedge clk) begin
    if (rst_any || state != ST_RUN || kick || wdog_hit || soft_go) wcnt <= '0;
    else                                                          wcnt <= wcnt + WW'(1);
  end

  // Sticky trip flag; only a hard reset cause (reset or ena low) clears it.
  always_ff @(posedge clk) begin
    if (hard_clr)      wdog_fired <= 1'b0;
    else if (wdog_hit) wdog_fired <= 1'b1;
  end
`else
  logic unused_kick;
  assign unused_kick = kick;
  assign wdog_hit    = 1'b0;
  assign wdog_fired  = 1'b0;
`endif

  // Sequencer FSM with registered channel resets, ready and boot mode.
  always_ff @(posedge clk) begin
    if (rst_any) begin
      state    <= ST_ASSERT;
      cnt      <= '0;
      pend     <= '1;
      soft_seq <= 1'b0;
      ch_reset <= '1;
      ready    <= 1'b0;
      if (hard_clr) boot_mode <= '0;
    end else begin
      case (state)
        ST_ASSERT: begin
          state <= ST_HOLD;
          cnt   <= '0;
        end
        ST_HOLD: begin
          if (cnt == CW'(HOLD - 1)) begin
            // The first release coincides with the last HOLD cycle.
            cnt      <= '0;
            ch_reset <= ch_reset & ~first;
            pend     <= pend & ~first;
            state    <= ST_REL;
            if (!soft_seq) boot_mode <= mode_pins;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_REL: begin
          if (pend == '0) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end else if (cnt == CW'(GAP - 1)) begin
            cnt      <= '0;
            ch_reset <= ch_reset & ~first;
            pend     <= pend & ~first;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RUN: begin
          if (wdog_hit) begin
            // Behaves like a one-cycle rst_any pulse: full sequence restarts.
            state    <= ST_ASSERT;
            cnt      <= '0;
            pend     <= '1;
            soft_seq <= 1'b0;
            ch_reset <= '1;
            ready    <= 1'b0;
          end else if (soft_go) begin
            state    <= ST_HOLD;
            cnt      <= '0;
            pend     <= soft_mask;
            soft_seq <= 1'b1;
            ch_reset <= soft_mask;
            ready    <= 1'b0;
          end
        end
        default: state <= ST_ASSERT;
      endcase
    end
  end

endmodule

// File: tb/tb_vc_rst_seq.sv
// Directed bench for vc_rst_seq at default parameters. Defining
// VC_RST_WDOG_EN shortens the watchdog to 64 cycles and adds trip checks.
module tb_vc_rst_seq;
  import vc_pkg::*;

  localparam int NCH   = VC_NCH;
  localparam int SYNC  = VC_SYNC;
  localparam int HOLD  = VC_HOLD;
  localparam int GAP   = VC_GAP;
  localparam int MODEW = VC_MODEW;
`ifdef VC_RST_WDOG_EN
  localparam int WD = 64;
`else
  localparam int WD = VC_WDOG;
`endif

  logic             clk = 1'b0;
  logic             reset, rst_n_pin, ena, soft_req, kick;
  logic [MODEW-1:0] mode_pins;
  logic [NCH-1:0]   soft_mask;
  logic [NCH-1:0]   ch_reset;
  logic [MODEW-1:0] boot_mode;
  logic             ready, wdog_fired;

  int n_tests = 0;
  int n_fail  = 0;

  vc_rst_seq #(
    .NCH   (NCH),
    .SYNC  (SYNC),
    .HOLD  (HOLD),
    .GAP   (GAP),
    .MODEW (MODEW),
    .WDOG  (WD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rst_n_pin  (rst_n_pin),
    .ena        (ena),
    .mode_pins  (mode_pins),
    .soft_req   (soft_req),
    .soft_mask  (soft_mask),
    .kick       (kick),
    .ch_reset   (ch_reset),
    .boot_mode  (boot_mode),
    .ready      (ready),
    .wdog_fired (wdog_fired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // z = ticks until the edge where rst_any is first seen low (HOLD entry).
  // Channel i then falls z+HOLD+i*GAP ticks from now; ready one tick after
  // the last channel.
  task automatic expect_full(input int z, input string tag);
    int total;
    logic [NCH-1:0] e;
    total = z + HOLD + (NCH - 1) * GAP + 1;
    for (int k = 1; k <= total; k++) begin
      tick();
      for (int i = 0; i < NCH; i++) e[i] = (k < z + HOLD + i * GAP);
      check($sformatf("%s ch_reset k=%0d", tag, k), 32'(ch_reset), 32'(e));
      check($sformatf("%s ready k=%0d", tag, k), 32'(ready), 32'(k == total));
    end
  endtask

  initial begin
    reset     = 1'b1;
    rst_n_pin = 1'b1;
    ena       = 1'b1;
    mode_pins = 2'b10;
    soft_req  = 1'b0;
    soft_mask = '0;
    kick      = 1'b0;
    repeat (3) tick();

    check("rst ch_reset", 32'(ch_reset), 32'h7);
    check("rst ready", 32'(ready), 32'h0);
    check("rst boot_mode", 32'(boot_mode), 32'h0);
    check("rst wdog_fired", 32'(wdog_fired), 32'h0);

    // Synchroniser is preset to asserted, so rst_any falls SYNC+1 edges
    // after reset drops; that edge is the HOLD entry.
    reset = 1'b0;
    expect_full(SYNC + 1, "full");
    check("boot captured", 32'(boot_mode), 32'h2);

    mode_pins = 2'b01;
    tick();
    check("boot held in RUN", 32'(boot_mode), 32'h2);

    // Zero mask is ignored.
    soft_req = 1'b1; soft_mask = 3'b000;
    tick();
    soft_req = 1'b0;
    check("mask0 ch_reset", 32'(ch_reset), 32'h0);
    check("mask0 ready", 32'(ready), 32'h1);

    // Soft reset of channel 2 only.
    soft_req = 1'b1; soft_mask = 3'b100;
    tick();
    soft_req = 1'b0; soft_mask = 3'b000;
    check("soft100 assert", 32'(ch_reset), 32'h4);
    check("soft100 ready low", 32'(ready), 32'h0);
    for (int j = 1; j <= 17; j++) begin
      tick();
      check($sformatf("soft100 ch_reset j=%0d", j), 32'(ch_reset), (j < 16) ? 32'h4 : 32'h0);
      check($sformatf("soft100 ready j=%0d", j), 32'(ready), 32'(j == 17));
    end

    // Soft reset of channels 1,2; a soft_req mid-sequence is ignored.
    soft_req = 1'b1; soft_mask = 3'b110;
    tick();
    soft_req = 1'b0; soft_mask = 3'b000;
    check("soft110 assert", 32'(ch_reset), 32'h6);
    for (int j = 1; j <= 21; j++) begin
      logic [NCH-1:0] e;
      if (j == 3) begin soft_req = 1'b1; soft_mask = 3'b001; end
      tick();
      soft_req = 1'b0; soft_mask = 3'b000;
      e = {1'(j < 20), 1'(j < 16), 1'b0};
      check($sformatf("soft110 ch_reset j=%0d", j), 32'(ch_reset), 32'(e));
      check($sformatf("soft110 ready j=%0d", j), 32'(ready), 32'(j == 21));
    end
    check("boot after soft", 32'(boot_mode), 32'h2);

    // ena low forces a full sequence and clears boot_mode.
    mode_pins = 2'b11;
    ena = 1'b0;
    tick();
    check("ena ch_reset", 32'(ch_reset), 32'h7);
    check("ena ready", 32'(ready), 32'h0);
    check("ena boot clr", 32'(boot_mode), 32'h0);
    ena = 1'b1;
    expect_full(1, "ena");
    check("ena boot", 32'(boot_mode), 32'h3);

    // Pad reset pulse while in REL replays the full sequence.
    ena = 1'b0;
    tick();
    ena = 1'b1;
    repeat (HOLD + 3) tick();
    check("rel before pad", 32'(ch_reset), 32'h6);
    rst_n_pin = 1'b0;
    tick();
    rst_n_pin = 1'b1;
    tick();
    expect_full(2, "pad");
    check("pad keeps boot", 32'(boot_mode), 32'h3);

`ifdef VC_RST_WDOG_EN
    // Kick every 32 cycles: never trips.
    for (int j = 1; j <= 100; j++) begin
      kick = (j % 32 == 0);
      tick();
      kick = 1'b0;
    end
    check("kick no trip", 32'(wdog_fired), 32'h0);
    check("kick ready", 32'(ready), 32'h1);
    kick = 1'b1;
    tick();
    kick = 1'b0;
    for (int j = 1; j <= 64; j++) begin
      tick();
      check($sformatf("wdog fired j=%0d", j), 32'(wdog_fired), 32'(j == 64));
    end
    check("wdog ch_reset", 32'(ch_reset), 32'h7);
    check("wdog ready", 32'(ready), 32'h0);
    rst_n_pin = 1'b0;
    tick();
    rst_n_pin = 1'b1;
    repeat (4) tick();
    check("wdog sticky pad", 32'(wdog_fired), 32'h1);
    ena = 1'b0;
    tick();
    ena = 1'b1;
    check("wdog clr ena", 32'(wdog_fired), 32'h0);
`else
    for (int j = 1; j <= WD + 100; j++) begin
      kick = (j == 7);
      tick();
      kick = 1'b0;
    end
    check("no wdog fired", 32'(wdog_fired), 32'h0);
    check("no wdog ready", 32'(ready), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
